// File: rtl/lcd_pkg.sv
// Shared constants and state type for the HD44780 character-LCD controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      INIT     = 3'd1,
      IDLE     = 3'd2,
      SETUP    = 3'd3,
      STROBE   = 3'd4,
      HOLD     = 3'd5
   } lcd_state_e;

   // Power-up command sequence: 8-bit/2-line, display on, clear, entry mode
   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;

   localparam logic [7:0] ADDR_LINE0   = 8'h80;
   localparam logic [7:0] ADDR_LINE1   = 8'hC0;

   localparam logic [7:0] CODE_LF      = 8'h0A;
   localparam logic [7:0] CODE_FF      = 8'h0C;

   localparam logic [1:0] INIT_LAST    = 2'd3;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = CMD_FUNC_SET;
         2'd1:    init_cmd = CMD_DISP_ON;
         2'd2:    init_cmd = CMD_CLEAR;
         default: init_cmd = CMD_ENTRY;
      endcase
   endfunction

   function automatic logic is_printable(input logic [7:0] c);
      is_printable = (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter shared by every timed phase; done while the count is zero.
module lcd_wait_timer #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         start,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)             cnt <= '0;
      else if (start)        cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only controller: power-up init, then character/control-code
// stream to a 2x16 display with line wrap.
module lcd_hd44780_ctrl
   import lcd_pkg::*;
#(
   parameter int PWR_CYC = 750000,
   parameter int EN_CYC  = 50,
   parameter int CMD_CYC = 2500,
   parameter int CLR_CYC = 100000
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en
);

   localparam int MAX_A = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
   localparam int MAX_B = (CMD_CYC > EN_CYC)  ? CMD_CYC : EN_CYC;
   localparam int MAXC  = (MAX_A > MAX_B)     ? MAX_A   : MAX_B;
   localparam int TW    = $clog2(MAXC + 1);

   // A phase of K cycles loads K-1 on entry and exits on the cycle the count hits zero
   localparam logic [TW-1:0] PWR_L = TW'(PWR_CYC - 1);
   localparam logic [TW-1:0] EN_L  = TW'(EN_CYC - 1);
   localparam logic [TW-1:0] CMD_L = TW'(CMD_CYC - 1);
   localparam logic [TW-1:0] CLR_L = TW'(CLR_CYC - 1);

   lcd_state_e    state;
   logic          armed;
   logic          in_init;
   logic [1:0]    init_idx;
   logic [7:0]    data_q;
   logic          rs_q;
   logic          line;
   logic [4:0]    col;
   logic          wrap_pend;
   logic [7:0]    pend_char;

   logic          tmr_start;
   logic [TW-1:0] tmr_load;
   logic          tmr_done;
   logic [TW-1:0] hold_load;

   lcd_wait_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rstb     (rstb),
      .start    (tmr_start),
      .load_val (tmr_load),
      .done     (tmr_done)
   );

   assign hold_load = (!rs_q && data_q == CMD_CLEAR) ? CLR_L : CMD_L;

   always_comb begin
      tmr_start = 1'b0;
      tmr_load  = '0;
      case (state)
         PWR_WAIT: if (!armed) begin
            tmr_start = 1'b1;
            tmr_load  = PWR_L;
         end
         SETUP: begin
            tmr_start = 1'b1;
            tmr_load  = EN_L;
         end
         STROBE: if (tmr_done) begin
            tmr_start = 1'b1;
            tmr_load  = hold_load;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= PWR_WAIT;
         armed     <= 1'b0;
         in_init   <= 1'b1;
         init_idx  <= 2'd0;
         data_q    <= 8'h00;
         rs_q      <= 1'b0;
         line      <= 1'b0;
         col       <= 5'd0;
         wrap_pend <= 1'b0;
         pend_char <= 8'h00;
      end else begin
         case (state)
            PWR_WAIT: begin
               if (!armed)        armed <= 1'b1;
               else if (tmr_done) state <= INIT;
            end
            INIT: begin
               data_q <= init_cmd(init_idx);
               rs_q   <= 1'b0;
               state  <= SETUP;
            end
            SETUP:  state <= STROBE;
            STROBE: if (tmr_done) state <= HOLD;
            HOLD: if (tmr_done) begin
               if (in_init) begin
                  if (init_idx == INIT_LAST) begin
                     in_init <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     init_idx <= init_idx + 2'd1;
                     data_q   <= init_cmd(init_idx + 2'd1);
                     state    <= SETUP;
                  end
               end else if (wrap_pend) begin
                  // second half of a wrap: the held character lands at column 0
                  wrap_pend <= 1'b0;
                  data_q    <= pend_char;
                  rs_q      <= 1'b1;
                  col       <= 5'd1;
                  state     <= SETUP;
               end else begin
                  state <= IDLE;
               end
            end
            IDLE: if (char_valid) begin
               if (is_printable(char_in)) begin
                  if (col == 5'd16) begin
                     data_q    <= line ? ADDR_LINE0 : ADDR_LINE1;
                     rs_q      <= 1'b0;
                     line      <= ~line;
                     col       <= 5'd0;
                     wrap_pend <= 1'b1;
                     pend_char <= char_in;
                  end else begin
                     data_q <= char_in;
                     rs_q   <= 1'b1;
                     col    <= col + 5'd1;
                  end
                  state <= SETUP;
               end else if (char_in == CODE_LF) begin
                  data_q <= line ? ADDR_LINE0 : ADDR_LINE1;
                  rs_q   <= 1'b0;
                  line   <= ~line;
                  col    <= 5'd0;
                  state  <= SETUP;
               end else if (char_in == CODE_FF) begin
                  data_q <= CMD_CLEAR;
                  rs_q   <= 1'b0;
                  line   <= 1'b0;
                  col    <= 5'd0;
                  state  <= SETUP;
               end
            end
            default: state <= PWR_WAIT;
         endcase
      end
   end

   assign char_ready = (state == IDLE);
   assign lcd_en     = (state == STROBE);
   assign lcd_data   = data_q;
   assign lcd_rs     = rs_q;
   assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Randomized bench for lcd_hd44780_ctrl: a bus monitor collects transfers and
// compares them with a character-level model of the display protocol.
module tb_lcd_hd44780_ctrl;

   localparam int PWR_CYC = 100;
   localparam int EN_CYC  = 4;
   localparam int CMD_CYC = 10;
   localparam int CLR_CYC = 40;
   localparam int BUDGET  = 2000;

   logic       clk = 1'b0;
   logic       rstb = 1'b0;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;
   logic       char_ready;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_en;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         rise;
      int         width;
      int         hold;
   } xfer_t;

   xfer_t mon_q[$];
   xfer_t exp_q[$];
   xfer_t cur;
   bit    busy_rec = 0;
   bit    prev_en = 0;
   int    m_line = 0;
   int    m_col = 0;

   lcd_hd44780_ctrl #(
      .PWR_CYC(PWR_CYC), .EN_CYC(EN_CYC), .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)
   ) dut (
      .clk        (clk),
      .rstb       (rstb),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .lcd_data   (lcd_data),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: one record per en pulse; hold = en-low cycles with rs/data unchanged
   always @(negedge clk) begin
      if (!rstb) begin
         busy_rec = 0;
         prev_en  = 0;
      end else begin
         if (lcd_en && !prev_en) begin
            if (busy_rec) mon_q.push_back(cur);
            cur.rs = lcd_rs; cur.data = lcd_data; cur.rise = cyc;
            cur.width = 1; cur.hold = 0; busy_rec = 1;
         end else if (lcd_en) begin
            cur.width++;
         end else if (busy_rec) begin
            if (lcd_data === cur.data && lcd_rs === cur.rs && char_ready !== 1'b1) cur.hold++;
            else begin
               mon_q.push_back(cur);
               busy_rec = 0;
            end
         end
         prev_en = lcd_en;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic void exp_push(input logic rs, input logic [7:0] d, input int hold);
      xfer_t x;
      x.rs = rs; x.data = d; x.rise = 0; x.width = EN_CYC; x.hold = hold;
      exp_q.push_back(x);
   endfunction

   // Character-level display model: what each input code should put on the bus
   task automatic model_char(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         if (m_col == 16) begin
            exp_push(1'b0, (m_line == 1) ? 8'h80 : 8'hC0, CMD_CYC);
            m_line = 1 - m_line;
            m_col = 0;
         end
         exp_push(1'b1, c, CMD_CYC);
         m_col++;
      end else if (c == 8'h0A) begin
         exp_push(1'b0, (m_line == 1) ? 8'h80 : 8'hC0, CMD_CYC);
         m_line = 1 - m_line;
         m_col = 0;
      end else if (c == 8'h0C) begin
         exp_push(1'b0, 8'h01, CLR_CYC);
         m_line = 0;
         m_col = 0;
      end
   endtask

   task automatic model_init();
      exp_push(1'b0, 8'h38, CMD_CYC);
      exp_push(1'b0, 8'h0C, CMD_CYC);
      exp_push(1'b0, 8'h01, CLR_CYC);
      exp_push(1'b0, 8'h06, CMD_CYC);
      m_line = 0;
      m_col = 0;
   endtask

   task automatic wait_ready(input string tag);
      int t = 0;
      while (char_ready !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
      if (char_ready !== 1'b1) begin
         checks++; failures++;
         $display("FAIL %s_timeout char_ready=%b required 1 within %0d cycles", tag, char_ready, BUDGET);
      end
      @(negedge clk);
   endtask

   task automatic send_char(input logic [7:0] c, output int acc);
      int t = 0;
      while (char_ready !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
      if (char_ready !== 1'b1) begin
         checks++; failures++;
         $display("FAIL send_timeout char_ready=%b required 1", char_ready);
      end
      char_in = c; char_valid = 1'b1; acc = cyc;
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   function automatic logic [7:0] rnd_print();
      return 8'($urandom_range(32, 126));
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (lcd_data !== 8'h00 || lcd_rs !== 1'b0 || lcd_en !== 1'b0 || lcd_rw !== 1'b0 || char_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got data=%h rs=%b en=%b rw=%b rdy=%b required 00 0 0 0 0",
                  lcd_data, lcd_rs, lcd_en, lcd_rw, char_ready);
      end
   endtask

   task automatic test_init();
      int rel, first;
      mon_q.delete(); exp_q.delete();
      @(negedge clk);
      rstb = 1'b1; rel = cyc;
      model_init();
      wait_ready("init");
      first = (mon_q.size() > 0) ? mon_q[0].rise - rel : -1;
      checks++;
      if (first < PWR_CYC || first > PWR_CYC + 4) begin
         failures++;
         $display("FAIL init_first_en got=%0d required %0d..%0d cycles after release", first, PWR_CYC, PWR_CYC + 4);
      end
      checks++;
      if (mon_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL init_count got=%0d required=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (mon_q[i].rs !== exp_q[i].rs || mon_q[i].data !== exp_q[i].data ||
             mon_q[i].width != EN_CYC || mon_q[i].hold != exp_q[i].hold) begin
            failures++;
            $display("FAIL init_xfer[%0d] got rs=%b data=%h w=%0d h=%0d required rs=%b data=%h w=%0d h=%0d", i,
                     mon_q[i].rs, mon_q[i].data, mon_q[i].width, mon_q[i].hold,
                     exp_q[i].rs, exp_q[i].data, EN_CYC, exp_q[i].hold);
         end
      end
      mon_q.delete(); exp_q.delete();
   endtask

   task automatic test_char_timing();
      int acc;
      bit e_en, e_rdy;
      send_char(8'h41, acc);
      model_char(8'h41);
      checks++;
      if (lcd_data !== 8'h41 || lcd_rs !== 1'b1 || lcd_en !== 1'b0 || char_ready !== 1'b0 || lcd_rw !== 1'b0) begin
         failures++;
         $display("FAIL char_setup got data=%h rs=%b en=%b rdy=%b rw=%b required 41 1 0 0 0",
                  lcd_data, lcd_rs, lcd_en, char_ready, lcd_rw);
      end
      for (int j = 2; j <= 16; j++) begin
         @(negedge clk);
         e_en  = (j >= 2 && j <= 5);
         e_rdy = (j == 16);
         checks++;
         if (lcd_en !== e_en || char_ready !== e_rdy || lcd_data !== 8'h41) begin
            failures++;
            $display("FAIL char_timing N+%0d got en=%b rdy=%b data=%h required en=%b rdy=%b data=41",
                     j, lcd_en, char_ready, lcd_data, e_en, e_rdy);
         end
      end
      @(negedge clk);
      mon_q.delete(); exp_q.delete();
   endtask

   task automatic test_wrap();
      int acc;
      logic [7:0] c;
      send_char(8'h0C, acc);
      model_char(8'h0C);
      for (int k = 0; k < 17; k++) begin
         c = rnd_print();
         send_char(c, acc);
         model_char(c);
      end
      while (char_ready !== 1'b1 && cyc - acc < 100) @(negedge clk);
      checks++;
      if (cyc - acc != 31) begin
         failures++;
         $display("FAIL wrap_ready_delay got=%0d required=31", cyc - acc);
      end
      @(negedge clk);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL wrap_count got=%0d required=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (mon_q[i].rs !== exp_q[i].rs || mon_q[i].data !== exp_q[i].data ||
             mon_q[i].width != EN_CYC || mon_q[i].hold != exp_q[i].hold) begin
            failures++;
            $display("FAIL wrap_xfer[%0d] got rs=%b data=%h w=%0d h=%0d required rs=%b data=%h w=%0d h=%0d", i,
                     mon_q[i].rs, mon_q[i].data, mon_q[i].width, mon_q[i].hold,
                     exp_q[i].rs, exp_q[i].data, EN_CYC, exp_q[i].hold);
         end
      end
      mon_q.delete(); exp_q.delete();
   endtask

   task automatic test_ctrl_codes();
      int acc;
      bit saw_en = 0;
      send_char(8'h0A, acc); model_char(8'h0A);
      send_char(8'h0C, acc); model_char(8'h0C);
      send_char(8'h07, acc); model_char(8'h07);
      checks++;
      if (char_ready !== 1'b1 || lcd_en !== 1'b0) begin
         failures++;
         $display("FAIL drop_next_cycle got rdy=%b en=%b required rdy=1 en=0", char_ready, lcd_en);
      end
      repeat (8) begin
         @(negedge clk);
         if (lcd_en !== 1'b0) saw_en = 1;
      end
      checks++;
      if (saw_en) begin
         failures++;
         $display("FAIL drop_no_strobe got en pulse=1 required 0");
      end
      checks++;
      if (mon_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL ctrl_count got=%0d required=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (mon_q[i].rs !== exp_q[i].rs || mon_q[i].data !== exp_q[i].data ||
             mon_q[i].width != EN_CYC || mon_q[i].hold != exp_q[i].hold) begin
            failures++;
            $display("FAIL ctrl_xfer[%0d] got rs=%b data=%h w=%0d h=%0d required rs=%b data=%h w=%0d h=%0d", i,
                     mon_q[i].rs, mon_q[i].data, mon_q[i].width, mon_q[i].hold,
                     exp_q[i].rs, exp_q[i].data, EN_CYC, exp_q[i].hold);
         end
      end
      mon_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      int acc, sel;
      logic [7:0] c;
      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)       c = rnd_print();
         else if (sel == 7) c = 8'h0A;
         else if (sel == 8) c = 8'h0C;
         else begin
            c = ($urandom_range(0, 1) == 1) ? (8'h80 | 8'($urandom_range(0, 127))) : 8'($urandom_range(0, 31));
            if (c == 8'h0A || c == 8'h0C) c = 8'h1B;
         end
         send_char(c, acc);
         model_char(c);
      end
      wait_ready("random");
      checks++;
      if (mon_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL random_count got=%0d required=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (mon_q[i].rs !== exp_q[i].rs || mon_q[i].data !== exp_q[i].data ||
             mon_q[i].width != EN_CYC || mon_q[i].hold != exp_q[i].hold) begin
            failures++;
            $display("FAIL random_xfer[%0d] got rs=%b data=%h w=%0d h=%0d required rs=%b data=%h w=%0d h=%0d", i,
                     mon_q[i].rs, mon_q[i].data, mon_q[i].width, mon_q[i].hold,
                     exp_q[i].rs, exp_q[i].data, EN_CYC, exp_q[i].hold);
         end
      end
      mon_q.delete(); exp_q.delete();
   endtask

   task automatic test_hold_valid();
      int acc, t;
      logic [7:0] c;
      for (int k = 0; k < 3; k++) begin
         c = rnd_print();
         send_char(c, acc);
         model_char(c);
         t = 0;
         // keep valid asserted with noise until the block is ready again
         while (t < 200) begin
            if (char_ready === 1'b1) break;
            char_valid = 1'b1;
            char_in = rnd_print();
            @(negedge clk);
            t++;
         end
         char_valid = 1'b0;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (mon_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL hold_valid_count got=%0d required=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (mon_q[i].rs !== exp_q[i].rs || mon_q[i].data !== exp_q[i].data ||
             mon_q[i].width != EN_CYC || mon_q[i].hold != exp_q[i].hold) begin
            failures++;
            $display("FAIL hold_valid_xfer[%0d] got rs=%b data=%h w=%0d h=%0d required rs=%b data=%h w=%0d h=%0d", i,
                     mon_q[i].rs, mon_q[i].data, mon_q[i].width, mon_q[i].hold,
                     exp_q[i].rs, exp_q[i].data, EN_CYC, exp_q[i].hold);
         end
      end
      mon_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_strobe();
      int acc, t = 0;
      send_char(rnd_print(), acc);
      while (lcd_en !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (lcd_en !== 1'b1) begin
         failures++;
         $display("FAIL rst_strobe_reach got en=%b required 1", lcd_en);
      end
      rstb = 1'b0;
      #1;
      checks++;
      if (lcd_en !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0 || char_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_strobe_immediate got en=%b data=%h rs=%b rdy=%b required 0 00 0 0",
                  lcd_en, lcd_data, lcd_rs, char_ready);
      end
      repeat (3) @(negedge clk);
      mon_q.delete(); exp_q.delete();
      rstb = 1'b1;
      model_init();
      wait_ready("rst_reinit");
      checks++;
      if (mon_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL reinit_count got=%0d required=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (mon_q[i].rs !== exp_q[i].rs || mon_q[i].data !== exp_q[i].data ||
             mon_q[i].width != EN_CYC || mon_q[i].hold != exp_q[i].hold) begin
            failures++;
            $display("FAIL reinit_xfer[%0d] got rs=%b data=%h w=%0d h=%0d required rs=%b data=%h w=%0d h=%0d", i,
                     mon_q[i].rs, mon_q[i].data, mon_q[i].width, mon_q[i].hold,
                     exp_q[i].rs, exp_q[i].data, EN_CYC, exp_q[i].hold);
         end
      end
      mon_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_init();
      test_char_timing();
      test_wrap();
      test_ctrl_codes();
      test_random();
      test_hold_valid();
      test_reset_strobe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
